// File: rtl/traffic_pkg.sv
// Shared lamp encodings, FSM state codes and sequencing helpers for the
// intersection scheduler.
package traffic_pkg;

    localparam int TL_W = 5;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'b00,
        LAMP_YELLOW = 2'b01,
        LAMP_GREEN  = 2'b10,
        LAMP_UNDEF  = 2'b11
    } lamp_t;

    // Code 7 is deliberately unnamed; the FSM treats it as corrupt state.
    typedef enum logic [2:0] {
        ST_ALL_RED   = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_NS_CLEAR  = 3'd3,
        ST_EW_GREEN  = 3'd4,
        ST_EW_YELLOW = 3'd5,
        ST_EW_CLEAR  = 3'd6
    } state_t;

    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_ALL_RED:   return ST_NS_GREEN;
            ST_NS_GREEN:  return ST_NS_YELLOW;
            ST_NS_YELLOW: return ST_NS_CLEAR;
            ST_NS_CLEAR:  return ST_EW_GREEN;
            ST_EW_GREEN:  return ST_EW_YELLOW;
            ST_EW_YELLOW: return ST_EW_CLEAR;
            ST_EW_CLEAR:  return ST_NS_GREEN;
            default:      return ST_ALL_RED;
        endcase
    endfunction

    function automatic logic is_green(input state_t s);
        return (s == ST_NS_GREEN) || (s == ST_EW_GREEN);
    endfunction

    function automatic logic is_clear(input state_t s);
        return (s == ST_NS_CLEAR) || (s == ST_EW_CLEAR);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter: load has priority, then the pedestrian cap, then a
// tick decrement. Exposes ==1 and ==0 detects for the sequencer.
import traffic_pkg::*;

module phase_timer #(
    parameter int              W       = TL_W,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_cap_en,
    input  logic [W-1:0] i_cap_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_is_one,
    output logic         o_is_zero
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_cap_en && (r_count > i_cap_val)) begin
            r_count <= i_cap_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_is_one  = (r_count == W'(1));
    assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/intersection_sched.sv
// Two-way intersection sequencer: fixed NS/EW cycle with peak-dependent
// green lengths, pedestrian green cut and walk during all-red clearance.
import traffic_pkg::*;

module intersection_sched #(
    parameter int GREEN_T     = 16,
    parameter int PEAK_MAIN_T = 24,
    parameter int PEAK_SIDE_T = 8,
    parameter int YELLOW_T    = 5,
    parameter int CLEAR_T     = 2,
    parameter int PED_CUT_T   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            enb,
    input  logic            peak,
    input  logic            ped_req,
    output logic [1:0]      light_ns,
    output logic [1:0]      light_ew,
    output logic [TL_W-1:0] time_left,
    output logic [2:0]      phase,
    output logic            phase_done,
    output logic            ped_walk
);

    localparam logic [TL_W-1:0] CLEAR_V = TL_W'(CLEAR_T);
    localparam logic [TL_W-1:0] CUT_V   = TL_W'(PED_CUT_T);

    state_t          r_state;
    logic            r_done;
    logic            r_walk;
    logic            r_pend;

    state_t          w_state_next;
    logic            w_load;
    logic [TL_W-1:0] w_load_val;
    logic            w_cap_en;
    logic            w_dec;
    logic            w_done_next;
    logic            w_walk_next;
    logic            w_pend_next;
    logic            w_pend_eff;
    logic [TL_W-1:0] w_tl;
    logic            w_one;
    logic            w_zero;

    // Green lengths read peak only here, i.e. at the moment of load.
    function automatic logic [TL_W-1:0] phase_dur(input state_t s, input logic pk);
        case (s)
            ST_NS_GREEN:               return pk ? TL_W'(PEAK_MAIN_T) : TL_W'(GREEN_T);
            ST_EW_GREEN:               return pk ? TL_W'(PEAK_SIDE_T) : TL_W'(GREEN_T);
            ST_NS_YELLOW, ST_EW_YELLOW: return TL_W'(YELLOW_T);
            default:                   return CLEAR_V;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_pend_eff   = r_pend | ped_req;
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = CLEAR_V;
        w_cap_en     = 1'b0;
        w_dec        = 1'b0;
        w_done_next  = 1'b0;
        w_walk_next  = r_walk;
        w_pend_next  = w_pend_eff;

        if (!enb || (r_state > ST_EW_CLEAR)) begin
            w_state_next = ST_ALL_RED;
            w_load       = 1'b1;
            w_walk_next  = 1'b0;
        end else if (tick && w_zero) begin
            w_state_next = ST_ALL_RED;
            w_load       = 1'b1;
            w_done_next  = 1'b1;
            w_walk_next  = 1'b0;
        end else if (tick && w_one) begin
            w_state_next = next_phase(r_state);
            w_load       = 1'b1;
            w_load_val   = phase_dur(w_state_next, peak);
            w_done_next  = 1'b1;
            w_walk_next  = is_clear(w_state_next) && w_pend_eff;
            if (is_clear(r_state) && r_walk) begin
                w_pend_next = ped_req;
            end
        end else begin
            w_cap_en = is_green(r_state) && w_pend_eff;
            w_dec    = tick;
        end
    end

    // NOTE: only control state is reset; there is no memory array here, and
    // asynchronous reset makes the lamps go red without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ALL_RED;
            r_done  <= 1'b0;
            r_walk  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_walk  <= w_walk_next;
            r_pend  <= w_pend_next;
        end
    end

    phase_timer #(
        .W       (TL_W),
        .RST_VAL (CLEAR_V)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_cap_en   (w_cap_en),
        .i_cap_val  (CUT_V),
        .i_dec      (w_dec),
        .o_count    (w_tl),
        .o_is_one   (w_one),
        .o_is_zero  (w_zero)
    );

    assign light_ns   = (r_state == ST_NS_GREEN)  ? LAMP_GREEN  :
                        (r_state == ST_NS_YELLOW) ? LAMP_YELLOW : LAMP_RED;
    assign light_ew   = (r_state == ST_EW_GREEN)  ? LAMP_GREEN  :
                        (r_state == ST_EW_YELLOW) ? LAMP_YELLOW : LAMP_RED;
    assign time_left  = w_tl;
    assign phase      = r_state;
    assign phase_done = r_done;
    assign ped_walk   = r_walk;

endmodule

// File: tb/tb_intersection_sched.sv
// Randomized bench for intersection_sched against a phase-table reference
// model; includes a fixed-cadence opening run and an async reset mid-yellow.
module tb_intersection_sched;

    localparam int GREEN = 16, MAIN = 24, SIDE = 8, YEL = 5, CLR = 2, CUT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, enb = 1'b0, peak = 1'b0, ped_req = 1'b0;
    logic [1:0] light_ns, light_ew;
    logic [4:0] time_left;
    logic [2:0] phase;
    logic       phase_done, ped_walk;

    always #5 clk = ~clk;

    intersection_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .enb        (enb),
        .peak       (peak),
        .ped_req    (ped_req),
        .light_ns   (light_ns),
        .light_ew   (light_ew),
        .time_left  (time_left),
        .phase      (phase),
        .phase_done (phase_done),
        .ped_walk   (ped_walk)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: phase number 0..6 as listed in the phase table.
    int m_ph, m_tl;
    bit m_pend, m_walk, m_done;

    function automatic int dur(input int ph, input bit pk);
        case (ph)
            1:       return pk ? MAIN : GREEN;
            4:       return pk ? SIDE : GREEN;
            2, 5:    return YEL;
            default: return CLR;
        endcase
    endfunction

    function automatic int lamp_ns(input int ph);
        return (ph == 1) ? 2 : (ph == 2) ? 1 : 0;
    endfunction

    function automatic int lamp_ew(input int ph);
        return (ph == 4) ? 2 : (ph == 5) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_tl = CLR; m_pend = 0; m_walk = 0; m_done = 0;
    endtask

    task automatic model_step(input bit e, input bit t, input bit p, input bit q);
        bit pend_now, green, clear_exit;
        int nph;
        pend_now = m_pend | q;
        green    = (m_ph == 1) || (m_ph == 4);
        m_done   = 0;
        if (!e) begin
            m_ph = 0; m_tl = CLR; m_walk = 0; m_pend = pend_now;
        end else if (t && m_tl == 1) begin
            nph        = (m_ph == 6) ? 1 : m_ph + 1;
            clear_exit = (m_ph == 3 || m_ph == 6) && m_walk;
            m_pend     = clear_exit ? q : pend_now;
            m_walk     = (nph == 3 || nph == 6) && pend_now;
            m_ph       = nph;
            m_tl       = dur(nph, p);
            m_done     = 1;
        end else if (t && m_tl == 0) begin
            m_ph = 0; m_tl = CLR; m_walk = 0; m_done = 1; m_pend = pend_now;
        end else begin
            if (green && pend_now && m_tl > CUT) m_tl = CUT;
            else if (t) m_tl = m_tl - 1;
            m_pend = pend_now;
        end
    endtask

    task automatic check_outputs();
        check("phase", phase, m_ph);
        check("light_ns", light_ns, lamp_ns(m_ph));
        check("light_ew", light_ew, lamp_ew(m_ph));
        check("time_left", time_left, m_tl);
        check("phase_done", phase_done, m_done);
        check("ped_walk", ped_walk, m_walk);
        check("lamps_exclusive", int'(light_ns != 2'b00 && light_ew != 2'b00), 0);
    endtask

    task automatic cycle(input bit e, input bit t, input bit p, input bit q);
        enb = e; tick = t; peak = p; ped_req = q;
        @(posedge clk);
        model_step(e, t, p, q);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_phase"}, phase, 0);
        check({tag, "_ns"}, light_ns, 0);
        check({tag, "_ew"}, light_ew, 0);
        check({tag, "_tl"}, time_left, CLR);
        check({tag, "_done"}, phase_done, 0);
        check({tag, "_walk"}, ped_walk, 0);
    endtask

    initial begin
        bit r_enb, r_peak, found, t, q;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check_outputs();

        // Fixed cadence: tick every 4 clk, off-peak, no pedestrians.
        for (int i = 0; i < 240; i++) cycle(1'b1, (i % 4) == 3, 1'b0, 1'b0);

        r_enb = 1; r_peak = 0;
        for (int i = 0; i < 6000; i++) begin
            if (r_enb && $urandom_range(0, 299) == 0) r_enb = 0;
            else if (!r_enb && $urandom_range(0, 19) == 0) r_enb = 1;
            if ($urandom_range(0, 79) == 0) r_peak = ~r_peak;
            t = ($urandom_range(0, 3) == 0);
            q = ($urandom_range(0, 59) == 0) ||
                ((m_ph == 1 || m_ph == 4) && (m_tl == 12 || m_tl == 3) &&
                 $urandom_range(0, 3) == 0);
            cycle(r_enb, t, r_peak, q);
        end

        // Walk the sequence into NS_YELLOW, then pull reset between edges.
        found = 0;
        for (int j = 0; j < 2000 && !found; j++) begin
            cycle(1'b1, (j % 2) == 0, 1'b0, 1'b0);
            if (m_ph == 2 && m_tl == 3) found = 1;
        end
        check("reach_ns_yellow", found, 1);
        tick = 0; ped_req = 0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        check_reset_values("held_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 80; k++) cycle(1'b1, (k % 2) == 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
